vgacon_text_ctrl: RTL and testbench
===================================

# vgacon_text_ctrl

Console sequencer for the VGA text peripheral's character buffer. It accepts character and cursor commands from the TinyQV host register interface and buffers them in a small FIFO. It executes them against the text buffer's single write port and combinational read port, handling cursor advance, newline, backspace, clear-screen and hardware scroll. The display path keeps its own independent read of the buffer; this block is the sole writer.

## Interface
- NUM_ROWS, 3, text rows
- NUM_COLS, 10, text columns
- FIFO_DEPTH, 4, command FIFO entries (power of two)
- clk  in  1  project clock (64 MHz)
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  one-cycle host write strobe
- cmd_data  in  10  bit9=0: char {color[8:7], ascii[6:0]}; bit9=1: cursor set, cell index in [4:0]
- vblank  in  1  vertical blanking from VGA timing
- ovf_clr  in  1  clears overflow flag
- ram_we  out  1  text buffer write enable
- ram_waddr  out  5  write cell index (row*NUM_COLS+col)
- ram_wdata  out  9  {color, ascii}
- ram_raddr  out  5  read cell index
- ram_rdata  in  9  combinational read data for ram_raddr
- cursor  out  5  current cursor cell index
- busy  out  1  state != IDLE or FIFO non-empty
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- overflow  out  1  sticky: a command was dropped

## Operation
- Push: cmd_valid && !fifo_full at the edge. Push while full is dropped and sets overflow, even if a pop occurs the same cycle.
- Overflow: cleared by ovf_clr; a simultaneous drop wins (stays 1).
- States: IDLE, WAIT_VBL, SCROLL_COPY, SCROLL_CLEAR, CLEAR_ALL.
- IDLE with FIFO non-empty pops one command per cycle and executes it in that cycle from the FIFO head:
  - Printable 0x20–0x7E: ram_we=1, waddr=cursor, wdata=cmd[8:0]; col+1.
  - 0x0A LF: col=0, row+1.
  - 0x0D CR: col=0.
  - 0x08 BS: col-1 if col>0, no write.
  - 0x0C FF: enter clear (CLEAR_ALL), cursor=0.
  - Other codes <0x20 and 0x7F: ignored, popped.
  - Cursor set: cursor=index if index < NUM_ROWS*NUM_COLS, else ignored.
- Column wrap: col advancing past NUM_COLS-1 gives col=0, row+1.
- Row advance past NUM_ROWS-1: row stays NUM_ROWS-1 and a scroll starts. Scroll is eager, triggered by the char/LF that caused the advance.
- SCROLL_COPY: counter i=0..(NUM_ROWS-1)*NUM_COLS-1; raddr=i+NUM_COLS, we=1, waddr=i, wdata=ram_rdata; one cell/cycle.
- SCROLL_CLEAR: last row cells written {2'b00,7'h20}, one/cycle; then IDLE.
- CLEAR_ALL: all cells written {2'b00,7'h20}, index 0 upward, one/cycle; then IDLE.
- No FIFO pops outside IDLE; pushes are accepted in every state.
- Reset mid-operation: aborts immediately; buffer contents are left as partially written (the buffer is not reset).

## Timing
- Reset values: ram_we=0, ram_waddr=0, ram_raddr=0, ram_wdata=0, cursor=0, busy=0, fifo_full=0, overflow=0, state IDLE.
- Push at edge E → earliest ram_we in cycle after E; cursor updates at the following edge.
- Back-to-back printable chars: one write per cycle.
- Scroll 3x10: 20 copy + 10 clear = 30 cycles of ram_we; returns to IDLE at the edge ending the last clear cycle.
- Clear screen: NUM_ROWS*NUM_COLS cycles.
- ram_raddr/ram_waddr/ram_wdata/ram_we are driven combinationally from registered state and the FIFO head; ram_rdata is sampled in the same cycle.
- Arithmetic: cursor is held internally as row/col; index = row*NUM_COLS+col, 5 bits, no overflow for ≤32 cells.

## Configuration
- VGACON_VBLANK_SYNC_EN defined: a scroll or clear first enters WAIT_VBL, then starts the cycle after vblank is sampled 1. This avoids tearing, and the full operation fits inside vblank.
- Undefined: WAIT_VBL is never entered, the vblank port is ignored, and scroll/clear start the next cycle.

## Structure
- Package vgacon_pkg holds:
  - State enum.
  - Control-char constants (LF, CR, BS, FF, SPACE).
  - Command bit positions (CMD_CURSOR_BIT=9).
  - Blank cell value {2'b00,7'h20}.
- Sub-module vgacon_cmd_fifo: FIFO_DEPTH x 10 register FIFO with push/pop/full/empty; drop-on-full logic stays in the parent.

## Test plan
- Reset, push 'A' (0x041) then 'B' (0x142) → writes cell 0=0x041 and cell 1=0x142 on consecutive cycles; cursor=2.
- Cursor set 9 (0x209), push 'X', push 'Y' → writes cell 9 and cell 10; cursor=11.
- Fill 30 cells with distinct chars, then push 'Z' → 20 copy writes (cell i ← old cell i+10), 10 writes of 0x020 to cells 20–29, then 'Z' at cell 20; cursor=21.
- With the FIFO stalled during a scroll, push 6 commands → first 4 accepted, overflow=1, fifo_full=1. Pulse ovf_clr with no drop → overflow=0.
- FF with VGACON_VBLANK_SYNC_EN, vblank=0 for 50 cycles → no ram_we. Raise vblank → 30 writes of 0x020 starting the cycle after; cursor=0.
- Assert rst_n=0 mid-scroll (cycle 7) → ram_we=0 immediately, cursor=0, busy=0; FIFO empty after release.

Source files
------------

// File: rtl/vgacon_pkg.sv
// Shared types and constants for the VGA text console sequencer.
// Optional vblank-synchronised scroll/clear is enabled by VGACON_VBLANK_SYNC_EN.
package vgacon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VBL,
        ST_SCROLL_COPY,
        ST_SCROLL_CLEAR,
        ST_CLEAR_ALL
    } vgacon_state_e;

    localparam int CMD_W          = 10;
    localparam int CELL_W         = 9;
    localparam int IDX_W          = 5;
    localparam int CMD_CURSOR_BIT = 9;

    localparam logic [6:0] CH_BS    = 7'h08;
    localparam logic [6:0] CH_LF    = 7'h0A;
    localparam logic [6:0] CH_FF    = 7'h0C;
    localparam logic [6:0] CH_CR    = 7'h0D;
    localparam logic [6:0] CH_SPACE = 7'h20;
    localparam logic [6:0] CH_TILDE = 7'h7E;

    localparam logic [CELL_W-1:0] BLANK_CELL = {2'b00, CH_SPACE};

    function automatic logic is_printable(input logic [6:0] ch);
        return (ch >= CH_SPACE) && (ch <= CH_TILDE);
    endfunction

endpackage

// File: rtl/vgacon_cmd_fifo.sv
// Register FIFO for host console commands; the parent decides when to push/pop.
// Head is valid only while empty is low.
module vgacon_cmd_fifo
    import vgacon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [CMD_W-1:0] i_wdata,
    output logic [CMD_W-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (i_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/vgacon_text_ctrl.sv
// Console sequencer: sole writer of the text buffer (chars, cursor, scroll, clear).
// Define VGACON_VBLANK_SYNC_EN to hold scroll/clear until vertical blanking.
module vgacon_text_ctrl
    import vgacon_pkg::*;
#(
    parameter int NUM_ROWS   = 3,
    parameter int NUM_COLS   = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [CMD_W-1:0]  cmd_data,
    input  logic              vblank,
    input  logic              ovf_clr,
    output logic              ram_we,
    output logic [IDX_W-1:0]  ram_waddr,
    output logic [CELL_W-1:0] ram_wdata,
    output logic [IDX_W-1:0]  ram_raddr,
    input  logic [CELL_W-1:0] ram_rdata,
    output logic [IDX_W-1:0]  cursor,
    output logic              busy,
    output logic              fifo_full,
    output logic              overflow
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLS - 1);
    localparam logic [IDX_W-1:0] COLS_I    = IDX_W'(NUM_COLS);
    localparam logic [IDX_W-1:0] CELLS_I   = IDX_W'(NUM_ROWS * NUM_COLS);
    localparam logic [IDX_W-1:0] CELL_LAST = IDX_W'(NUM_ROWS * NUM_COLS - 1);
    localparam logic [IDX_W-1:0] COPY_LAST = IDX_W'((NUM_ROWS - 1) * NUM_COLS - 1);
    localparam logic [IDX_W-1:0] ROW_BASE  = IDX_W'((NUM_ROWS - 1) * NUM_COLS);

    vgacon_state_e    r_state;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [IDX_W-1:0] r_idx;
    logic             r_ovf;

    logic [CMD_W-1:0] w_head;
    logic             w_full, w_empty, w_push, w_pop, w_drop;
    logic             w_is_cur, w_print, w_lf, w_cr, w_bs, w_ff, w_wrap, w_scroll;
    logic [6:0]       w_ch;
    logic [IDX_W-1:0] w_set_idx, w_cursor;

    assign w_push = cmd_valid && !w_full;
    assign w_drop = cmd_valid && w_full;
    assign w_pop  = (r_state == ST_IDLE) && !w_empty;

    vgacon_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (cmd_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_is_cur  = w_head[CMD_CURSOR_BIT];
    assign w_ch      = w_head[6:0];
    assign w_set_idx = w_head[IDX_W-1:0];
    assign w_print   = !w_is_cur && is_printable(w_ch);
    assign w_lf      = !w_is_cur && (w_ch == CH_LF);
    assign w_cr      = !w_is_cur && (w_ch == CH_CR);
    assign w_bs      = !w_is_cur && (w_ch == CH_BS);
    assign w_ff      = !w_is_cur && (w_ch == CH_FF);
    assign w_wrap    = w_print && (r_col == LAST_COL);
    assign w_scroll  = (w_wrap || w_lf) && (r_row == LAST_ROW);
    assign w_cursor  = IDX_W'(r_row) * COLS_I + IDX_W'(r_col);

`ifdef VGACON_VBLANK_SYNC_EN
    logic r_pend_clr;
`else
    logic w_unused;
    assign w_unused = vblank;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
`ifdef VGACON_VBLANK_SYNC_EN
            r_pend_clr <= 1'b0;
`endif
        end else begin
            if (w_drop)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;

            case (r_state)
                ST_IDLE: if (w_pop) begin
                    if (w_is_cur) begin
                        if (w_set_idx < CELLS_I) begin
                            r_row <= ROW_W'(w_set_idx / COLS_I);
                            r_col <= COL_W'(w_set_idx % COLS_I);
                        end
                    end else if (w_print || w_lf) begin
                        r_col <= (w_lf || w_wrap) ? '0 : r_col + COL_W'(1);
                        if ((w_lf || w_wrap) && r_row != LAST_ROW)
                            r_row <= r_row + ROW_W'(1);
                    end else if (w_cr) begin
                        r_col <= '0;
                    end else if (w_bs) begin
                        if (r_col != '0) r_col <= r_col - COL_W'(1);
                    end else if (w_ff) begin
                        r_row <= '0;
                        r_col <= '0;
                    end
                    // Scroll is eager: the row stays on the last line and the shift starts now.
                    if (w_scroll || w_ff) begin
                        r_idx <= '0;
`ifdef VGACON_VBLANK_SYNC_EN
                        r_state    <= ST_WAIT_VBL;
                        r_pend_clr <= w_ff;
`else
                        r_state <= w_ff ? ST_CLEAR_ALL : ST_SCROLL_COPY;
`endif
                    end
                end
`ifdef VGACON_VBLANK_SYNC_EN
                ST_WAIT_VBL: if (vblank) r_state <= r_pend_clr ? ST_CLEAR_ALL : ST_SCROLL_COPY;
`endif
                ST_SCROLL_COPY: begin
                    if (r_idx == COPY_LAST) begin
                        r_idx   <= ROW_BASE;
                        r_state <= ST_SCROLL_CLEAR;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_SCROLL_CLEAR, ST_CLEAR_ALL: begin
                    if (r_idx == CELL_LAST) begin
                        r_idx   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Buffer port is combinational so copy reads and writes land in the same cycle.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = w_cursor;
        ram_raddr = '0;
        ram_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pop && w_print) begin
                    ram_we    = 1'b1;
                    ram_wdata = w_head[CELL_W-1:0];
                end
            end
            ST_SCROLL_COPY: begin
                ram_we    = 1'b1;
                ram_waddr = r_idx;
                ram_raddr = r_idx + COLS_I;
                ram_wdata = ram_rdata;
            end
            ST_SCROLL_CLEAR, ST_CLEAR_ALL: begin
                ram_we    = 1'b1;
                ram_waddr = r_idx;
                ram_wdata = BLANK_CELL;
            end
            default: ;
        endcase
    end

    assign cursor    = w_cursor;
    assign busy      = (r_state != ST_IDLE) || !w_empty;
    assign fifo_full = w_full;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_vgacon_text_ctrl.sv
// Self-checking bench for vgacon_text_ctrl: directed scenarios plus random command
// streams compared against a screen/cursor model of the console rules.
`timescale 1ns/1ps
module tb_vgacon_text_ctrl;
    localparam int R = 3;
    localparam int C = 10;
    localparam int N = R * C;

    logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, vblank = 1'b1, ovf_clr = 1'b0;
    logic [9:0] cmd_data = '0;
    logic       ram_we, busy, fifo_full, overflow;
    logic [4:0] ram_waddr, ram_raddr, cursor;
    logic [8:0] ram_wdata, ram_rdata;

    vgacon_text_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .vblank(vblank), .ovf_clr(ovf_clr), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .cursor(cursor), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Text buffer behind the DUT, plus a log of every write with its edge index.
    typedef struct packed { logic [31:0] cyc; logic [4:0] a; logic [8:0] d; } wr_t;
    logic [8:0] ram [0:31];
    wr_t        wlog[$];
    int         cyc = 0;
    assign ram_rdata = ram[ram_raddr];

    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
            wlog.push_back({32'(cyc), ram_waddr, ram_wdata});
        end
        cyc <= cyc + 1;
    end

    // Reference model: expected screen and cursor
    logic [8:0] scr [0:N-1];
    int m_row = 0, m_col = 0;
    int n_chk = 0, n_err = 0;

    function automatic void m_newline();
        if (m_row == R - 1) begin
            for (int i = 0; i < N - C; i++) scr[i] = scr[i + C];
            for (int i = N - C; i < N; i++) scr[i] = 9'h020;
        end else begin
            m_row++;
        end
    endfunction

    function automatic void m_apply(input logic [9:0] c);
        int ch;
        ch = int'(c[6:0]);
        if (c[9]) begin
            if (int'(c[4:0]) < N) begin
                m_row = int'(c[4:0]) / C;
                m_col = int'(c[4:0]) % C;
            end
        end else if (ch >= 32 && ch <= 126) begin
            scr[m_row * C + m_col] = c[8:0];
            m_col++;
            if (m_col == C) begin
                m_col = 0;
                m_newline();
            end
        end else if (ch == 10) begin
            m_col = 0;
            m_newline();
        end else if (ch == 13) begin
            m_col = 0;
        end else if (ch == 8) begin
            if (m_col > 0) m_col--;
        end else if (ch == 12) begin
            for (int i = 0; i < N; i++) scr[i] = 9'h020;
            m_row = 0;
            m_col = 0;
        end
    endfunction

    function automatic logic [9:0] fill_val(input int i);
        return 10'(((i % 4) << 7) | (8'h30 + i));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [9:0] c);
        cmd_valid = 1'b1;
        cmd_data  = c;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [9:0] c);
        int k = 0;
        while (fifo_full && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("push_wait", 32'(fifo_full), 32'(0));
        m_apply(c);
        push(c);
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while (busy && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", 32'(busy), 32'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_row = 0;
        m_col = 0;
        @(negedge clk);
    endtask

    task automatic cmp_screen(input string tag);
        for (int i = 0; i < N; i++) chk(tag, 32'(ram[i]), 32'(scr[i]));
        chk({tag, "_cursor"}, 32'(cursor), 32'(m_row * C + m_col));
    endtask

    initial begin
        int t0, start, k, r;
        logic [1:0] col;
        logic [9:0] c;

        // Reset values
        @(negedge clk);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_waddr", 32'(ram_waddr), 0);
        chk("rst_raddr", 32'(ram_raddr), 0);
        chk("rst_wdata", 32'(ram_wdata), 0);
        chk("rst_cursor", 32'(cursor), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clear screen (form feed), vblank-gated when that build option is on
`ifdef VGACON_VBLANK_SYNC_EN
        vblank = 1'b0;
`endif
        wlog.delete();
        t0 = cyc;
        send(10'h00C);
`ifdef VGACON_VBLANK_SYNC_EN
        repeat (50) @(negedge clk);
        chk("vbl_hold_we", 32'(wlog.size()), 0);
        chk("vbl_hold_busy", 32'(busy), 1);
        start = cyc + 1;
        vblank = 1'b1;
`else
        start = t0 + 2;
`endif
        wait_idle(100);
        chk("clr_count", 32'(wlog.size()), 30);
        for (int i = 0; i < N && i < wlog.size(); i++) begin
            chk("clr_addr", 32'(wlog[i].a), 32'(i));
            chk("clr_data", 32'(wlog[i].d), 32'h020);
            chk("clr_cyc", wlog[i].cyc, 32'(start + i));
        end
        cmp_screen("clr");

        // 'A' then 'B' back to back
        do_reset();
        wlog.delete();
        t0 = cyc;
        send(10'h041);
        send(10'h142);
        wait_idle(20);
        chk("ab_count", 32'(wlog.size()), 2);
        if (wlog.size() >= 2) begin
            chk("ab_a0", 32'(wlog[0].a), 0);
            chk("ab_d0", 32'(wlog[0].d), 32'h041);
            chk("ab_c0", wlog[0].cyc, 32'(t0 + 1));
            chk("ab_a1", 32'(wlog[1].a), 1);
            chk("ab_d1", 32'(wlog[1].d), 32'h142);
            chk("ab_c1", wlog[1].cyc, 32'(t0 + 2));
        end
        chk("ab_cursor", 32'(cursor), 2);

        // Cursor set to 9, then a row wrap
        wlog.delete();
        send(10'h209);
        send(10'h058);
        send(10'h059);
        wait_idle(20);
        chk("cs_count", 32'(wlog.size()), 2);
        if (wlog.size() >= 2) begin
            chk("cs_a0", 32'(wlog[0].a), 9);
            chk("cs_d0", 32'(wlog[0].d), 32'h058);
            chk("cs_a1", 32'(wlog[1].a), 10);
            chk("cs_d1", 32'(wlog[1].d), 32'h059);
            chk("cs_c1", wlog[1].cyc, wlog[0].cyc + 1);
        end
        cmp_screen("cs");

        // Fill all cells, then one more char lands after the scroll
        do_reset();
        wlog.delete();
        for (int i = 0; i < N; i++) send(fill_val(i));
        send(10'h05A);
        wait_idle(200);
        chk("scr_count", 32'(wlog.size()), 61);
        if (wlog.size() >= 61) begin
            for (int i = 0; i < N - C; i++) begin
                chk("scr_copy_a", 32'(wlog[30 + i].a), 32'(i));
                chk("scr_copy_d", 32'(wlog[30 + i].d), 32'(fill_val(i + C) & 10'h1FF));
            end
            for (int i = 0; i < C; i++) begin
                chk("scr_blank_a", 32'(wlog[50 + i].a), 32'(20 + i));
                chk("scr_blank_d", 32'(wlog[50 + i].d), 32'h020);
            end
            chk("scr_span", wlog[59].cyc - wlog[30].cyc, 29);
            chk("scr_z_a", 32'(wlog[60].a), 20);
            chk("scr_z_d", 32'(wlog[60].d), 32'h05A);
        end
        chk("scr_cursor", 32'(cursor), 21);
        cmp_screen("scr");

        // Overflow while the FIFO is stalled by a scroll
        send(10'h21D);
        send(10'h041);
        repeat (3) @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            if (j < 4) m_apply(10'h061 + 10'(j));
            push(10'h061 + 10'(j));
        end
        chk("ovf_full", 32'(fifo_full), 1);
        chk("ovf_set", 32'(overflow), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        chk("ovf_still_full", 32'(fifo_full), 1);
        wait_idle(200);
        cmp_screen("ovf");

        // Reset in the middle of a scroll copy
        send(10'h21D);
        send(10'h042);
        k = 0;
        while (!(ram_we && ram_raddr == 5'd10) && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("mid_copy_seen", 32'(ram_raddr), 10);
        push(10'h070);
        push(10'h071);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(ram_we), 0);
        chk("abort_cursor", 32'(cursor), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_full", 32'(fifo_full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_row = 0;
        m_col = 0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_we", 32'(ram_we), 0);

        // Known screen again, then random command streams
        send(10'h00C);
        wait_idle(100);
        cmp_screen("ff2");
        for (int n = 0; n < 400; n++) begin
            r   = $urandom_range(0, 99);
            col = 2'($urandom_range(0, 3));
            if (r < 65)      c = {1'b0, col, 7'($urandom_range(32, 126))};
            else if (r < 75) c = {1'b0, col, 7'h0A};
            else if (r < 80) c = {1'b0, col, 7'h0D};
            else if (r < 86) c = {1'b0, col, 7'h08};
            else if (r < 88) c = {1'b0, col, 7'h0C};
            else if (r < 95) c = {1'b1, 4'($urandom), 5'($urandom_range(0, 31))};
            else if (r < 97) c = {1'b0, col, 7'h7F};
            else             c = {1'b0, col, 7'($urandom_range(0, 31))};
            send(c);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            if (n % 50 == 49) begin
                wait_idle(300);
                cmp_screen("rnd");
            end
        end
        chk("rnd_ovf", 32'(overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
